// File: rtl/seq_add_ctrl_pkg.sv
// Shared definitions for the sequential multi-word adder controller.
//   WORD_W  : width of one beat and of the shared adder.
//   state_e : controller FSM states.
package seq_add_ctrl_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_add_ctrl_if.sv
// Request/result bundle for seq_add_ctrl.
//   Request : in_valid, in_ready, a, b, sub
//   Result  : out_valid, out_ready, sum, cout, ovf
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The controller raises in_ready only while idle and out_valid only
// while holding a finished result; the result stays stable until out_ready
// is seen high.
//   master : requester/consumer side
//   slave  : controller side
interface seq_add_ctrl_if
    import seq_add_ctrl_pkg::*;
#(
    parameter int NWORDS = 4
);
    localparam int W = WORD_W * NWORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/seq_add_ctrl_add16_core.sv
// add16_core: single 16-bit adder with carry in/out, shared by all beats.
//   a, b : 16-bit addends
//   cin  : carry in
//   s    : 16-bit sum
//   cout : carry out of bit 15
module add16_core
    import seq_add_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/seq_add_ctrl.sv
// seq_add_ctrl: adds or subtracts two W-bit operands (W = 16*NWORDS) one
// 16-bit beat per cycle through a single shared adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/result bundle (slave side)
//   dbg_state  : current FSM state
// Subtraction is A + ~B + 1: B is inverted at acceptance and the carry
// register is seeded with sub, so the datapath only ever adds.
module seq_add_ctrl
    import seq_add_ctrl_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_add_ctrl_if.slave bus,
    output state_e       dbg_state
);

    localparam int W     = WORD_W * NWORDS;
    localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NWORDS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;        // already inverted for subtraction
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WORD_W-1:0] slice_a;
    logic [WORD_W-1:0] slice_b;
    logic [WORD_W-1:0] add_s;
    logic              add_co;

    // Beat selection: the counter picks the current 16-bit slice.
    assign slice_a = a_q[beat_q * WORD_W +: WORD_W];
    assign slice_b = b_q[beat_q * WORD_W +: WORD_W];

    add16_core u_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        beat_d  = beat_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[beat_q * WORD_W +: WORD_W] = add_s;
                carry_d = add_co;
                if (beat_q == LAST_BEAT) begin
                    // add_s[WORD_W-1] is the top bit of the final sum.
                    cout_d  = add_co;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_s[WORD_W-1] != a_q[W-1]);
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            beat_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            beat_q  <= beat_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Bench for seq_add_ctrl (NWORDS = 4): directed corner cases, randomized
// operations against a plain-arithmetic reference, backpressure,
// back-to-back requests and mid-operation reset.
module tb_seq_add_ctrl;
    import seq_add_ctrl_pkg::*;

    localparam int NW = 4;
    localparam int W  = WORD_W * NW;

    logic   clk;
    logic   rst_n;
    state_e dbg_state;
    int     checks;
    int     errors;

    seq_add_ctrl_if #(.NWORDS(NW)) bus ();

    seq_add_ctrl #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: true signed/unsigned arithmetic on widened operands.
    function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, output logic [W-1:0] r,
                                   output logic c, output logic v);
        logic signed [W:0] sr;
        logic [W:0]        ur;
        if (!s) begin
            ur = {1'b0, x} + {1'b0, y};
            c  = ur[W];
            sr = $signed({x[W-1], x}) + $signed({y[W-1], y});
        end else begin
            c  = (x >= y);
            sr = $signed({x[W-1], x}) - $signed({y[W-1], y});
        end
        r = sr[W-1:0];
        v = (sr[W] != sr[W-1]);
    endfunction

    // Driver: call #1 after a rising edge with the controller idle.
    // Returns number of edges from acceptance (inclusive) to out_valid.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, output int lat);
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = y;
        bus.sub      = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.sub      = 1'($urandom_range(0, 1));
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        bus.sub = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum got %h expected 0", bus.sum); end
        checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got cout=%b ovf=%b expected 0 0", bus.cout, bus.ovf); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic         ts [6];
        logic [W-1:0] es [6];
        logic         ec [6];
        logic         ev [6];
        int lat;
        ta[0] = 64'h0000_0000_0000_FFFF; tb[0] = 64'h1; ts[0] = 1'b0; es[0] = 64'h0000_0000_0001_0000; ec[0] = 1'b0; ev[0] = 1'b0;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'h1; ts[1] = 1'b0; es[1] = 64'h0;                   ec[1] = 1'b1; ev[1] = 1'b0;
        ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'h1; ts[2] = 1'b0; es[2] = 64'h8000_0000_0000_0000; ec[2] = 1'b0; ev[2] = 1'b1;
        ta[3] = 64'h0;                   tb[3] = 64'h1; ts[3] = 1'b1; es[3] = 64'hFFFF_FFFF_FFFF_FFFF; ec[3] = 1'b0; ev[3] = 1'b0;
        ta[4] = 64'h5;                   tb[4] = 64'h3; ts[4] = 1'b1; es[4] = 64'h2;                   ec[4] = 1'b1; ev[4] = 1'b0;
        ta[5] = 64'h8000_0000_0000_0000; tb[5] = 64'h1; ts[5] = 1'b1; es[5] = 64'h7FFF_FFFF_FFFF_FFFF; ec[5] = 1'b1; ev[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ts[i], lat);
            checks++; if (lat !== NW + 1) begin errors++; $display("FAIL dir%0d_latency got %0d expected %0d", i, lat, NW + 1); end
            checks++; if (bus.sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h expected %h", i, bus.sum, es[i]); end
            checks++; if (bus.cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b expected %b", i, bus.cout, ec[i]); end
            checks++; if (bus.ovf !== ev[i]) begin errors++; $display("FAIL dir%0d_ovf got %b expected %b", i, bus.ovf, ev[i]); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_ready_in_done got %b expected 0", i, bus.in_ready); end
            release_result();
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_release got valid=%b ready=%b expected 0 1", i, bus.out_valid, bus.in_ready); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, er;
        logic         s, ec, ev;
        int lat, mode, dly;
        for (int i = 0; i < 40; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 4);
            if (mode == 1) x = '1;
            if (mode == 2) y = {1'b0, {(W-1){1'b1}}};
            if (mode == 3) y = 64'(x[15:0]);
            ref_op(x, y, s, er, ec, ev);
            do_op(x, y, s, lat);
            checks++; if (lat !== NW + 1) begin errors++; $display("FAIL rnd%0d_latency got %0d expected %0d", i, lat, NW + 1); end
            checks++; if (bus.sum !== er || bus.cout !== ec || bus.ovf !== ev)
                begin errors++; $display("FAIL rnd%0d_result got %h/%b/%b expected %h/%b/%b", i, bus.sum, bus.cout, bus.ovf, er, ec, ev); end
            dly = $urandom_range(0, 3);
            repeat (dly) @(posedge clk);
            #1;
            release_result();
            // Result must persist while idle.
            checks++; if (bus.sum !== er || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_idle_hold got %h ready=%b expected %h ready=1", i, bus.sum, bus.in_ready, er); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, y, er;
        logic         ec, ev;
        int lat;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        ref_op(x, y, 1'b0, er, ec, ev);
        do_op(x, y, 1'b0, lat);
        checks++; if (bus.sum !== er) begin errors++; $display("FAIL bp_result got %h expected %h", bus.sum, er); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = {$urandom, $urandom};
            @(posedge clk);
            #1;
            checks++; if (bus.sum !== er || bus.cout !== ec || bus.ovf !== ev)
                begin errors++; $display("FAIL bp_hold%0d got %h/%b/%b expected %h/%b/%b", i, bus.sum, bus.cout, bus.ovf, er, ec, ev); end
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_flags%0d got valid=%b ready=%b expected 1 0", i, bus.out_valid, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        release_result();
        checks++; if (dbg_state !== IDLE || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got state=%0d ready=%b expected %0d 1", dbg_state, bus.in_ready, IDLE); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic         ec, ev;
        int lat;
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, lat);
        // Request held high during the releasing edge must not be taken.
        bus.in_valid  = 1'b1;
        bus.a         = 64'h0000_0000_0001_0000;
        bus.b         = 64'h0000_0000_0000_0001;
        bus.sub       = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++; if (dbg_state !== IDLE || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_same_cycle got state=%0d expected %0d", dbg_state, IDLE); end
        ref_op(64'h0000_0000_0001_0000, 64'h1, 1'b1, er, ec, ev);
        do_op(64'h0000_0000_0001_0000, 64'h1, 1'b1, lat);
        checks++; if (lat !== NW + 1 || bus.sum !== er || bus.cout !== ec)
            begin errors++; $display("FAIL b2b_second got lat=%0d %h/%b expected %0d %h/%b", lat, bus.sum, bus.cout, NW + 1, er, ec); end
        release_result();
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.in_valid = 1'b1;
        bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b        = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.sub      = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0)
            begin errors++; $display("FAIL midrst_outputs got %h/%b/%b expected 0/0/0", bus.sum, bus.cout, bus.ovf); end
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_flags got ready=%b valid=%b expected 1 0", bus.in_ready, bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(64'h2, 64'h3, 1'b0, lat);
        checks++; if (lat !== NW + 1 || bus.sum !== 64'h5 || bus.cout !== 1'b0 || bus.ovf !== 1'b0)
            begin errors++; $display("FAIL midrst_next got lat=%0d %h/%b/%b expected %0d 5/0/0", lat, bus.sum, bus.cout, bus.ovf, NW + 1); end
        release_result();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_add_ctrl.md
SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 Parameter NWORDS, default 4, SHALL set the number of 16-bit beats; operand width W = 16*NWORDS.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  controller can accept an operation.
REQ-006 a  input  W  operand A, sampled on acceptance.
REQ-007 b  input  W  operand B, sampled on acceptance.
REQ-008 sub  input  1  0 = A+B, 1 = A-B; sampled on acceptance.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  W  result, modulo 2^W.
REQ-012 cout  output  1  carry out of bit W-1 (for sub: 1 = no borrow).
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready.
REQ-016 On acceptance: register a, b (b inverted when sub=1) and sub; set the beat counter to 0; set the carry register to sub; go to RUN.
REQ-017 In RUN, each cycle SHALL add the beat-k 16-bit slices of A and B' plus the carry register through one shared 16-bit adder, write the 16-bit result into sum[16k+15:16k], and store that beat's carry out.
REQ-018 The beat counter SHALL increment each RUN cycle; after beat NWORDS-1 the FSM SHALL go to DONE.
REQ-019 The final beat SHALL set cout to its carry out and set ovf = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]).
REQ-020 out_valid SHALL be 1 only in DONE; latency from the acceptance edge to out_valid high = NWORDS+1 rising edges (5 for the default).
REQ-021 sum, cout and ovf SHALL hold stable while out_valid=1 and out_ready=0 (backpressure, unbounded).
REQ-022 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge; no new acceptance in the same cycle.
REQ-023 in_valid and operand changes while in RUN or DONE SHALL be ignored.
REQ-024 sum SHALL keep the last result in IDLE until the next acceptance overwrites it beat by beat.
REQ-025 NWORDS=1 SHALL be legal: a single RUN cycle.

Reset
REQ-026 When rst_n=0, the block SHALL immediately enter IDLE with in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, beat counter=0 and carry register=0.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no partial result retained.

Structure
REQ-028 A shared package SHALL hold WORD_W=16 and the FSM state enumeration {IDLE, RUN, DONE}.
REQ-029 The block SHALL instantiate exactly one 16-bit adder sub-module, add16_core, with inputs a[15:0], b[15:0] and cin, and outputs s[15:0] and cout.
REQ-030 Slice selection and carry chaining SHALL be the only datapath logic outside add16_core.

Verification
REQ-031 Add, NWORDS=4, a=0x0000_0000_0000_FFFF, b=0x1, sub=0 -> out_valid on the 5th edge after acceptance; sum=0x0000_0000_0001_0000; cout=0; ovf=0.
REQ-032 Add, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0; cout=1; ovf=0.
REQ-033 Add, a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0x8000_0000_0000_0000; ovf=1; cout=0.
REQ-034 Subtract, a=0x0, b=0x1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF; cout=0; ovf=0. Subtract, a=5, b=3, sub=1 -> sum=2; cout=1.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and a -> outputs stable and in_ready=0; then pulse out_ready -> IDLE on the next edge.
REQ-036 Assert rst_n=0 during beat 2 of an operation -> outputs zero immediately; in_ready=1; the next operation (a=2, b=3, sub=0) gives sum=5.
